// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider controller for DIV/DIVU/REM/REMU, sitting beside E.
// Latency: XLEN+1 cycles from start to the done pulse; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: div_stallE holds F/D/E while a divide is pending; flushE kills the divide with no done pulse.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   div_startE, div_opE    divide valid in E; funct3[1:0] (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   srcaE, srcbE           dividend / divisor after forwarding
//   flushE                 abort the in-flight divide, or block a start
//   div_stallE             hold the front of the pipeline
//   div_doneE, div_resultE one-cycle done pulse and its quotient/remainder
//   div_busy               iteration in progress
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_startE,
  input  logic [1:0]      div_opE,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            flushE,
  output logic            div_stallE,
  output logic            div_doneE,
  output logic [XLEN-1:0] div_resultE,
  output logic            div_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, stateNext;
  logic              remSel;      // latched op[1]: remainder rather than quotient
  logic              signA, signB;
  logic [XLEN-1:0]   remReg, quoReg, divisorReg, resultReg;
  logic [CNT_W-1:0]  count;

  // Start-side decode
  logic              isSignedIn, srcaNeg, srcbNeg, divByZero, overflow, special, accept;
  logic [XLEN-1:0]   magA, magB, specialResult;

  always_comb begin
    isSignedIn = ~div_opE[0];
    srcaNeg    = isSignedIn & srcaE[XLEN-1];
    srcbNeg    = isSignedIn & srcbE[XLEN-1];
    magA       = srcaNeg ? (~srcaE + 1'b1) : srcaE;
    magB       = srcbNeg ? (~srcbE + 1'b1) : srcbE;
    divByZero  = (srcbE == '0);
    overflow   = isSignedIn & (srcaE == MIN_NEG) & (srcbE == '1);
    special    = divByZero | overflow;
    accept     = (state == IDLE) & div_startE & ~flushE;
    if (divByZero)
      specialResult = div_opE[1] ? srcaE : '1;
    else
      specialResult = div_opE[1] ? '0 : MIN_NEG;
  end

  // One restoring step. The shifted partial remainder needs XLEN+1 bits, but
  // after a subtract it is always below the divisor, so XLEN bits suffice to store.
  logic [XLEN:0]     remShift;
  logic              geq, lastIter;
  logic [XLEN-1:0]   remIter, quoIter, finalResult;

  always_comb begin
    remShift = {remReg, quoReg[XLEN-1]};
    geq      = (remShift >= {1'b0, divisorReg});
    remIter  = geq ? (remShift[XLEN-1:0] - divisorReg) : remShift[XLEN-1:0];
    quoIter  = {quoReg[XLEN-2:0], geq};
    lastIter = (count == CNT_W'(XLEN-1));
    // Signs are latched as zero for unsigned ops, so no op check is needed here.
    if (remSel)
      finalResult = signA ? (~remIter + 1'b1) : remIter;
    else
      finalResult = (signA ^ signB) ? (~quoIter + 1'b1) : quoIter;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = special ? DONE : BUSY;
      BUSY: begin
        if (flushE)        stateNext = IDLE;
        else if (lastIter) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;  // start is ignored: the same instruction is still in E
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remSel     <= 1'b0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      resultReg  <= '0;
      count      <= '0;
    end else if (accept) begin
      remSel     <= div_opE[1];
      signA      <= srcaNeg;
      signB      <= srcbNeg;
      remReg     <= '0;
      quoReg     <= magA;
      divisorReg <= magB;
      count      <= '0;
      if (special) resultReg <= specialResult;
    end else if ((state == BUSY) && !flushE) begin
      remReg <= remIter;
      quoReg <= quoIter;
      count  <= count + CNT_W'(1);
      if (lastIter) resultReg <= finalResult;
    end
  end

  assign div_stallE  = ~flushE & (((state == IDLE) & div_startE) | (state == BUSY));
  assign div_doneE   = (state == DONE) & ~flushE;
  assign div_busy    = (state == BUSY);
  assign div_resultE = resultReg;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed scenarios plus randomized operands checked
// against a plain-arithmetic reference of RISC-V divide semantics.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_startE;
  logic [1:0]  div_opE;
  logic [31:0] srcaE, srcbE;
  logic        flushE;
  logic        div_stallE, div_doneE, div_busy;
  logic [31:0] div_resultE;

  int nAssert = 0;
  int nFail   = 0;
  logic [31:0] lastRes = '0;

  div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .div_startE(div_startE), .div_opE(div_opE),
    .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE), .div_stallE(div_stallE),
    .div_doneE(div_doneE), .div_resultE(div_resultE), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension results, straight from the ISA rules.
  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int refDoneCycle(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one divide, hold start while stalled, and report when done appeared.
  // stallBad flags any cycle before done with stall low, or stall high in the done cycle.
  task automatic runDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int doneCyc, output logic [31:0] res, output logic stallBad);
    doneCyc  = -1;
    res      = '0;
    stallBad = 1'b0;
    @(negedge clk);
    div_startE = 1'b1; div_opE = op; srcaE = a; srcbE = b;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (div_doneE) begin
        doneCyc = c;
        res     = div_resultE;
        if (div_stallE) stallBad = 1'b1;
        break;
      end
      if (!div_stallE) stallBad = 1'b1;
    end
    div_startE = 1'b0;
  endtask

  task automatic runCheck(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expRes);
    int dc;
    logic [31:0] r;
    logic sb;
    runDiv(op, a, b, dc, r, sb);
    check({tag, "_result"}, r, expRes);
    check({tag, "_doneCycle"}, 32'(dc), 32'(refDoneCycle(op, a, b)));
    check({tag, "_stall"}, {31'd0, sb}, 32'd0);
    lastRes = r;
  endtask

  initial begin
    logic        sawDone;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_n = 1'b0; div_startE = 1'b0; div_opE = 2'd0; srcaE = '0; srcbE = '0; flushE = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall",  {31'd0, div_stallE}, 32'd0);
    check("reset_done",   {31'd0, div_doneE},  32'd0);
    check("reset_busy",   {31'd0, div_busy},   32'd0);
    check("reset_result", div_resultE,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed results
    runCheck("div_100_7",      2'd0, 32'd100,        32'd7,          32'h0000_000E);
    runCheck("rem_100_7",      2'd2, 32'd100,        32'd7,          32'h0000_0002);
    runCheck("div_m7_2",       2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    runCheck("rem_m7_2",       2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    runCheck("divu_max_2",     2'd1, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF);
    runCheck("remu_max_2",     2'd3, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001);
    runCheck("div_5_0",        2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF);
    runCheck("remu_5_0",       2'd3, 32'd5,          32'd0,          32'h0000_0005);
    runCheck("div_ovf",        2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    runCheck("rem_ovf",        2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000);
    runCheck("div_100_7_again",2'd0, 32'd100,        32'd7,          32'h0000_000E);

    // Flush in BUSY cycle 10: back to IDLE, no done, result register untouched
    @(negedge clk);
    div_startE = 1'b1; div_opE = 2'd0; srcaE = 32'd1000; srcbE = 32'd3;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    #1;
    check("flush_busy_c10", {31'd0, div_busy}, 32'd1);
    flushE = 1'b1;
    #1;
    check("flush_stall_c10", {31'd0, div_stallE}, 32'd0);
    @(negedge clk);
    flushE = 1'b0; div_startE = 1'b0;
    #1;
    check("flush_busy_c11",  {31'd0, div_busy},   32'd0);
    check("flush_stall_c11", {31'd0, div_stallE}, 32'd0);
    check("flush_result",    div_resultE,         lastRes);
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (div_doneE) sawDone = 1'b1;
    end
    check("flush_no_done", {31'd0, sawDone}, 32'd0);
    runCheck("div_9_3", 2'd0, 32'd9, 32'd3, 32'd3);

    // Flush in IDLE blocks the start
    @(negedge clk);
    div_startE = 1'b1; div_opE = 2'd1; srcaE = 32'd50; srcbE = 32'd5; flushE = 1'b1;
    @(negedge clk);
    div_startE = 1'b0; flushE = 1'b0;
    #1;
    check("idle_flush_busy", {31'd0, div_busy}, 32'd0);

    // Reset mid-operation in BUSY cycle 5
    @(negedge clk);
    div_startE = 1'b1; div_opE = 2'd0; srcaE = 32'd1000; srcbE = 32'd3;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst_n = 1'b0; div_startE = 1'b0;
    #1;
    check("rst_mid_stall",  {31'd0, div_stallE}, 32'd0);
    check("rst_mid_done",   {31'd0, div_doneE},  32'd0);
    check("rst_mid_busy",   {31'd0, div_busy},   32'd0);
    check("rst_mid_result", div_resultE,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (div_doneE || div_busy) sawDone = 1'b1;
    end
    check("rst_mid_no_done", {31'd0, sawDone}, 32'd0);

    // Back-to-back: second start lands in the IDLE cycle right after DONE
    runCheck("b2b_6_2", 2'd0, 32'd6, 32'd2, 32'd3);
    runCheck("b2b_8_4", 2'd0, 32'd8, 32'd4, 32'd2);

    // Randomized operands against the reference
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       begin ra = $urandom; rb = 32'd0; end
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
        4:       begin ra = 32'(-int'($urandom_range(0, 200))); rb = 32'(-int'($urandom_range(1, 20))); end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      runCheck($sformatf("rand%0d", i), rop, ra, rb, refResult(rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
